adder4_bist: RTL and testbench
==============================

ADDER4_BIST -- requirements
Module: adder4_bist

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the cycles each vector is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: run request, sampled in IDLE or DONE.
REQ-005 SHALL have port A, output, 4 bits: addend A driven to the 4-bit adder under test.
REQ-006 SHALL have port B, output, 4 bits: addend B driven to the adder under test.
REQ-007 SHALL have port C0, output, 1 bit: carry-in driven to the adder under test.
REQ-008 SHALL have port F, input, 4 bits: sum returned by the adder under test.
REQ-009 SHALL have port C4, input, 1 bit: carry-out returned by the adder under test.
REQ-010 SHALL have port busy, output, 1 bit: high in the SETTLE and CHECK states.
REQ-011 SHALL have port done, output, 1 bit: high in the DONE state.
REQ-012 SHALL have port pass, output, 1 bit: high in DONE when err_cnt is 0.
REQ-013 SHALL have port err_cnt, output, 10 bits: number of mismatching vectors in the current or last run.
REQ-014 SHALL have port first_fail, output, 9 bits: index of the first mismatching vector.
REQ-015 SHALL have port fail_seen, output, 1 bit: first_fail holds a valid index.

Function
REQ-016 SHALL keep a 9-bit vector index idx and drive C0=idx[8], A=idx[7:4], B=idx[3:0] directly from registers, with no combinational path from F or C4.
REQ-017 SHALL implement the states IDLE, SETTLE, CHECK and DONE.
REQ-018 SHALL, in IDLE or DONE with start=1, clear idx, the wait counter, err_cnt, first_fail and fail_seen, and go to SETTLE.
REQ-019 SHALL, in SETTLE, increment the wait counter and go to CHECK once the counter equals SETTLE-1.
REQ-020 SHALL, in CHECK, compare {C4,F} with the 5-bit expected sum A+B+C0.
REQ-021 SHALL, on a mismatch in CHECK, increment err_cnt, and, if fail_seen=0, load first_fail with idx and set fail_seen.
REQ-022 SHALL, in CHECK, go to DONE when idx=511; otherwise it SHALL increment idx, clear the wait counter and go to SETTLE.
REQ-023 SHALL make each vector take exactly SETTLE+1 cycles, so done rises 512*(SETTLE+1) cycles after the start edge (1536 cycles for SETTLE=2).
REQ-024 SHALL hold idx at 511 and keep A, B, C0, err_cnt, first_fail and fail_seen stable in DONE until the next start.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL size err_cnt so that it cannot wrap; the maximum value 512 SHALL be representable.
REQ-027 SHALL hold pass at 0 outside DONE.

Reset
REQ-028 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, idx=0, wait counter=0, and A=0, B=0, C0=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0.
REQ-029 SHALL, when reset arrives mid-run, abandon the run; after rst_n returns to 1 the block SHALL stay in IDLE until start.

Verification
REQ-030 SHALL be verified as follows: correct behavioural adder, SETTLE=2, start pulse -> done at cycle 1536, pass=1, err_cnt=0, fail_seen=0.
REQ-031 SHALL be verified as follows: F[0] stuck at 0 -> err_cnt=256, first_fail=1, fail_seen=1, pass=0.
REQ-032 SHALL be verified as follows: C4 stuck at 0 -> err_cnt=256, first_fail=31 (A=1, B=15, C0=0), pass=0.
REQ-033 SHALL be verified as follows: rst_n pulsed low at idx 100 -> all outputs return to 0 at once and the block stays in IDLE; a new start then runs the full 1536 cycles with counters cleared.
REQ-034 SHALL be verified as follows: start re-pulsed mid-run -> no effect; start pulsed in DONE -> counters cleared and a new run starts at idx 0.
REQ-035 SHALL be verified as follows: SETTLE=1 with an adder model that has a 1-cycle delay -> sampling happens one cycle after the vector is driven and the result is pass=1.

Source files
------------

// File: rtl/adder4_bist.sv
// -----------------------------------------------------------------------------
// adder4_bist
//
// Built-in self test for an external 4-bit adder. The controller walks a 9-bit
// vector index through all 512 combinations of {C0, A, B}. Each vector is held
// for SETTLE cycles so the adder can settle. The returned {C4, F} is then
// compared against A+B+C0 in one CHECK cycle. Mismatches are counted, and the
// first failing index is latched.
//
// Parameter
//   SETTLE      cycles each vector is held before it is sampled (1..15)
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       run request, honoured only in IDLE or DONE
//   A, B, C0    vector driven to the adder under test (straight from idx)
//   F, C4       sum and carry-out returned by the adder under test
//   busy        high while a run is in progress (SETTLE / CHECK)
//   done        high once all 512 vectors have been checked
//   pass        high in DONE when no vector mismatched
//   err_cnt     number of mismatching vectors (0..512, never wraps)
//   first_fail  index {C0,A,B} of the first mismatching vector
//   fail_seen   first_fail holds a valid index
//   dbg_state_o current controller state, for debug and checkers
//
// Handshake: start is a level sampled on every rising edge. A 1 seen in IDLE
// or DONE launches a fresh run. A 1 seen while busy is ignored. There is no
// ready/ack; done stays high until the next accepted start.
// -----------------------------------------------------------------------------
module adder4_bist #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       C0,
    input  logic [3:0] F,
    input  logic       C4,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_cnt,
    output logic [8:0] first_fail,
    output logic       fail_seen,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // The wait counter runs 0..SETTLE-1 inside SETTLE. The one CHECK cycle
    // makes each vector exactly SETTLE+1 cycles long.
    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
    localparam logic [8:0] IDX_LAST  = 9'd511;

    state_e     state_q;
    logic [8:0] idx_q;
    logic [3:0] wait_q;
    logic [9:0] err_cnt_q;
    logic [8:0] first_fail_q;
    logic       fail_seen_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic [4:0] expected_sum;
    logic       mismatch;

    // The reference sum comes purely from the index register. The adder
    // response only feeds the comparator, so it never reaches A/B/C0.
    always_comb begin
        expected_sum = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0]} + {4'd0, idx_q[8]};
        mismatch     = ({C4, F} != expected_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 9'd0;
            wait_q       <= 4'd0;
            err_cnt_q    <= 10'd0;
            first_fail_q <= 9'd0;
            fail_seen_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_q        <= 9'd0;
                        wait_q       <= 4'd0;
                        err_cnt_q    <= 10'd0;
                        first_fail_q <= 9'd0;
                        fail_seen_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        state_q      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt_q <= err_cnt_q + 10'd1;
                        if (!fail_seen_q) begin
                            first_fail_q <= idx_q;
                            fail_seen_q  <= 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        // pass has to include the mismatch from this final
                        // vector, which is not yet in err_cnt_q.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == 10'd0) && !mismatch;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 9'd1;
                        wait_q  <= 4'd0;
                        state_q <= ST_SETTLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign C0          = idx_q[8];
    assign A           = idx_q[7:4];
    assign B           = idx_q[3:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_cnt_q;
    assign first_fail  = first_fail_q;
    assign fail_seen   = fail_seen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder4_bist.sv
// -----------------------------------------------------------------------------
// tb_adder4_bist
//
// Two BIST instances share one clock and one reset:
//   dut2 : SETTLE=2, drives a combinational adder model
//   dut1 : SETTLE=1, drives an adder model with one cycle of latency
// Each adder model can be faulted: F[0] stuck at 0, C4 stuck at 0, or an
// arbitrary per-vector XOR corruption table.
// The expected error list comes from walking all 512 (a,b,c) triples and
// collecting every index whose returned value differs from a+b+c.
// -----------------------------------------------------------------------------
module tb_adder4_bist;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- dut2 (SETTLE=2) ----------------
    logic       start2;
    logic [3:0] a2, b2, f2;
    logic       c0_2, c4_2;
    logic       busy2, done2, pass2, fs2;
    logic [9:0] err2;
    logic [8:0] ff2;
    logic [1:0] dbg2;

    // ---------------- dut1 (SETTLE=1) ----------------
    logic       start1;
    logic [3:0] a1, b1, f1;
    logic       c0_1, c4_1;
    logic       busy1, done1, pass1, fs1;
    logic [9:0] err1;
    logic [8:0] ff1;
    logic [1:0] dbg1;

    // ---------------- fault environment ----------------
    int         fault_mode;      // 0 good, 1 F0 stuck 0, 2 C4 stuck 0, 3 xor table
    logic [4:0] bad_xor [512];
    logic [4:0] dly_q;

    int checks;
    int errors;
    int sel;                     // 0 observes dut2, 1 observes dut1

    adder4_bist #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .A(a2), .B(b2), .C0(c0_2), .F(f2), .C4(c4_2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_fail(ff2), .fail_seen(fs2), .dbg_state_o(dbg2)
    );

    adder4_bist #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(a1), .B(b1), .C0(c0_1), .F(f1), .C4(c4_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail(ff1), .fail_seen(fs1), .dbg_state_o(dbg1)
    );

    // Adder under test: true sum, then the selected fault applied.
    function automatic logic [4:0] adder_out(input int mode, input logic [8:0] v,
                                             input logic [4:0] x);
        int         sum;
        logic [4:0] s;
        sum = int'(v[7:4]) + int'(v[3:0]) + int'(v[8]);
        s   = 5'(sum);
        case (mode)
            1:       s[0] = 1'b0;
            2:       s[4] = 1'b0;
            3:       s = s ^ x;
            default: ;
        endcase
        return s;
    endfunction

    assign {c4_2, f2} = adder_out(fault_mode, {c0_2, a2, b2}, bad_xor[{c0_2, a2, b2}]);

    always @(posedge clk) dly_q <= adder_out(fault_mode, {c0_1, a1, b1}, bad_xor[{c0_1, a1, b1}]);
    assign {c4_1, f1} = dly_q;

    // ---------------- observation mux ----------------
    logic [8:0] obs_vec;
    logic       obs_busy, obs_done, obs_pass, obs_fs;
    logic [9:0] obs_err;
    logic [8:0] obs_ff;

    always_comb begin
        if (sel == 1) begin
            obs_vec = {c0_1, a1, b1}; obs_busy = busy1; obs_done = done1;
            obs_pass = pass1; obs_fs = fs1; obs_err = err1; obs_ff = ff1;
        end else begin
            obs_vec = {c0_2, a2, b2}; obs_busy = busy2; obs_done = done2;
            obs_pass = pass2; obs_fs = fs2; obs_err = err2; obs_ff = ff2;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start2 = v;
    endtask

    task automatic randomize_faults(input int force_idx);
        int n;
        for (int i = 0; i < 512; i++) bad_xor[i] = 5'd0;
        n = $urandom_range(1, 40);
        repeat (n) bad_xor[$urandom_range(0, 511)] = 5'($urandom_range(1, 31));
        if (force_idx >= 0) bad_xor[force_idx] = 5'($urandom_range(1, 31));
    endtask

    // Reference model: every vector whose returned value is not a+b+c fails.
    task automatic model(output int e_err, output int e_first, output int e_fs);
        logic [8:0] exp_q[$];
        int         idx;
        exp_q = {};
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    idx = c * 256 + a * 16 + b;
                    if (int'(adder_out(fault_mode, 9'(idx), bad_xor[idx])) != a + b + c)
                        exp_q.push_back(9'(idx));
                end
        e_err   = exp_q.size();
        e_first = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
        e_fs    = (exp_q.size() > 0) ? 1 : 0;
    endtask

    // One full run on the selected instance. mid_k > 0 re-pulses start while
    // busy so that the edge after cycle mid_k samples it.
    task automatic run_check(input string tag, input int s, input int mid_k,
                             input int e_err, input int e_first, input int e_fs);
        int total;
        int seq_err;
        int done_cyc;
        int exp_idx;
        total    = 512 * (s + 1);
        seq_err  = 0;
        done_cyc = -1;
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        // Right after the start edge: counters cleared, running at vector 0.
        check({tag, "_clr_err"}, int'(obs_err), 0);
        check({tag, "_clr_fs"},  int'(obs_fs),  0);
        check({tag, "_clr_ff"},  int'(obs_ff),  0);
        check({tag, "_clr_vec"}, int'(obs_vec), 0);
        check({tag, "_busy0"},   int'(obs_busy), 1);
        check({tag, "_done0"},   int'(obs_done), 0);
        for (int k = 1; k <= total + 4; k++) begin
            @(negedge clk);
            set_start(k == mid_k);
            exp_idx = k / (s + 1);
            if (exp_idx > 511) exp_idx = 511;
            if (int'(obs_vec) != exp_idx)              seq_err++;
            if (obs_busy != (k < total))               seq_err++;
            if (obs_done != (k >= total))              seq_err++;
            if (k < total && obs_pass)                 seq_err++;
            if (obs_done && done_cyc < 0)              done_cyc = k;
        end
        check({tag, "_seq"},      seq_err,  0);
        check({tag, "_done_cyc"}, done_cyc, total);
        check({tag, "_err"},      int'(obs_err),  e_err);
        check({tag, "_first"},    int'(obs_ff),   e_first);
        check({tag, "_fs"},       int'(obs_fs),   e_fs);
        check({tag, "_pass"},     int'(obs_pass), (e_err == 0) ? 1 : 0);
        // Results stay frozen in DONE.
        repeat (20) @(negedge clk);
        check({tag, "_hold_err"}, int'(obs_err),  e_err);
        check({tag, "_hold_ff"},  int'(obs_ff),   e_first);
        check({tag, "_hold_vec"}, int'(obs_vec),  511);
        check({tag, "_hold_done"}, int'(obs_done), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e_err, e_first, e_fs, n;
        checks = 0; errors = 0; sel = 0;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; fault_mode = 0;
        for (int i = 0; i < 512; i++) bad_xor[i] = 5'd0;

        repeat (2) @(negedge clk);
        check("rst_vec",  int'({c0_2, a2, b2}), 0);
        check("rst_busy", int'(busy2), 0);
        check("rst_done", int'(done2), 0);
        check("rst_pass", int'(pass2), 0);
        check("rst_err",  int'(err2),  0);
        check("rst_ff",   int'(ff2),   0);
        check("rst_fs",   int'(fs2),   0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy2), 0);
        check("idle_done", int'(done2), 0);

        // Good adder; then F[0] stuck with a start re-pulse mid-run; C4 stuck.
        fault_mode = 0; run_check("good", 2, 0, 0, 0, 0);
        fault_mode = 1; run_check("f0",   2, 700, 256, 1, 1);
        fault_mode = 2; run_check("c4",   2, 0, 256, 31, 1);

        // Random corruption tables, including the first and last vector.
        fault_mode = 3;
        randomize_faults(511); model(e_err, e_first, e_fs);
        run_check("rnd_last", 2, $urandom_range(10, 1400), e_err, e_first, e_fs);
        randomize_faults(0); model(e_err, e_first, e_fs);
        run_check("rnd_first", 2, $urandom_range(10, 1400), e_err, e_first, e_fs);
        randomize_faults(-1); model(e_err, e_first, e_fs);
        run_check("rnd", 2, 0, e_err, e_first, e_fs);

        // Every vector wrong: err_cnt must reach 512 without wrapping.
        for (int i = 0; i < 512; i++) bad_xor[i] = 5'($urandom_range(1, 31));
        model(e_err, e_first, e_fs);
        run_check("all_bad", 2, 0, e_err, e_first, e_fs);

        // Reset in the middle of a failing run, at vector 100.
        fault_mode = 1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (int'({c0_2, a2, b2}) != 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", int'({c0_2, a2, b2}), 100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vec",  int'({c0_2, a2, b2}), 0);
        check("mid_rst_busy", int'(busy2), 0);
        check("mid_rst_done", int'(done2), 0);
        check("mid_rst_pass", int'(pass2), 0);
        check("mid_rst_err",  int'(err2),  0);
        check("mid_rst_ff",   int'(ff2),   0);
        check("mid_rst_fs",   int'(fs2),   0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", int'(busy2), 0);
        check("post_rst_done", int'(done2), 0);
        check("post_rst_vec",  int'({c0_2, a2, b2}), 0);
        run_check("after_rst", 2, 0, 256, 1, 1);

        // SETTLE=1 instance with a one-cycle-latency adder.
        sel = 1;
        fault_mode = 0; run_check("dly_good", 1, 0, 0, 0, 0);
        fault_mode = 3;
        randomize_faults(-1); model(e_err, e_first, e_fs);
        run_check("dly_rnd", 1, $urandom_range(10, 900), e_err, e_first, e_fs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
